mem_stage_lsu: RTL
==================

# mem_stage_lsu

Parametrised memory-stage load/store unit for the 5-stage RISC-V pipeline, sitting between the EX/MEM register and writeback. It replaces the single-cycle, fixed-32-bit memory stage with three additions: a handshaked data-memory port that tolerates wait states, a stall output, and misaligned/illegal-access detection. It supports RV32 and RV64 data widths and drives the MEM/WB pipeline register.

## Interface
- XLEN, 32: data width, 32 or 64; NB = XLEN/8 byte lanes, OW = log2(NB) offset bits
- ADDR_W, 32: data address width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- valid_m, reg_write_m, mem_read_m, mem_write_m, result_src_m  in  1 each  M-stage control
- funct3_m  in  3  access size/sign
- rd_m  in  5  destination register
- pc_plus4_m, alu_result_m, write_data_m  in  XLEN each  M-stage data; alu_result_m[ADDR_W-1:0] is the address
- stall_m  out  1  hold IF..M stages
- dmem_req, dmem_we  out  1 each  request / write
- dmem_be  out  NB  byte enables
- dmem_addr  out  ADDR_W  address, lane-aligned (low OW bits zero)
- dmem_wdata  out  XLEN  lane-positioned store data
- dmem_ready  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  load data
- valid_w, reg_write_w, result_src_w, fault_w  out  1 each  WB-stage control
- rd_w  out  5
- pc_plus4_w, alu_result_w, read_data_w  out  XLEN each

## Operation
- Access type from funct3: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only). Any other value with mem op is illegal.
- off = address[OW-1:0]. Misaligned: H with off[0]!=0; W/WU with off[1:0]!=0; D with off!=0.
- Memory op = valid_m & (mem_read_m | mem_write_m). A misaligned or illegal memory op issues no request and sets stall_m=0. WB captures a bubble with fault_w=1 and alu_result_w = the faulting address.
- Store: dmem_be = size mask (1/3/F/FF) << off. dmem_wdata = store data shifted left by 8*off.
- Load: lane = dmem_rdata >> 8*off, truncated to size. Sign-extend for B/H/W; zero-extend for BU/HU/WU. D loads are taken as-is.
- FSM states:
  - IDLE: a legal memory op asserts dmem_req combinationally.
    - Store with ready: completes, stay in IDLE.
    - Load with ready: go to WAIT.
    - No ready: go to REQ.
  - REQ: dmem_req=1, request outputs held.
    - ready with store: complete, go to IDLE.
    - ready with load: go to WAIT.
  - WAIT: dmem_req=0.
    - rvalid: load completes, go to IDLE.
- stall_m = legal memory op & not completing this cycle.
- dmem_rvalid outside WAIT is ignored. dmem_ready outside a req cycle is ignored.
- WB register updates every cycle:
  - stall_m=1 or valid_m=0: bubble (valid_w=0, reg_write_w=0, fault_w=0).
  - Otherwise: M-stage fields; read_data_w = formatted load data on load completion, else 0.

## Timing
- Reset: state IDLE; every output register 0; dmem_req=0.
- Reset mid-REQ/WAIT aborts the access. The memory model is reset alongside.
- Upstream holds all M inputs stable while stall_m=1. The block does not latch them.
- Store with ready in request cycle: 0 stall cycles; WB valid next edge.
- Load with zero wait: request cycle + rvalid cycle = 1 stall cycle; WB valid the edge after rvalid.
- Each cycle ready is withheld adds one stall cycle. Each cycle rvalid is withheld adds one stall cycle.
- Non-memory instructions pass to WB with 1-cycle latency and never stall.

## Test plan
- XLEN=32, SW addr 0x100, data 0xDEADBEEF, ready=1 -> one req cycle, be=1111, wdata=0xDEADBEEF, stall_m=0; next edge valid_w=1, reg_write_w=0.
- LB addr 0x103, rdata 0x80xxxxxx, ready after 2 cycles, rvalid 1 cycle later -> be=0001<<3 unused for load, stall_m high 3 cycles, read_data_w=0xFFFFFF80.
- LHU addr 0x102, rdata 0xBEEF1234 -> read_data_w=0x0000BEEF. SH addr 0x101 -> no dmem_req, stall_m=0, fault_w=1, alu_result_w=0x101.
- XLEN=64: LD addr 0x08 with rdata 0x0123456789ABCDEF returns the same value; LW addr 0x0C with rdata 0x80000000_00000000 returns 0xFFFFFFFF80000000; funct3 111 -> fault_w=1.
- Reset asserted in WAIT -> next cycle state IDLE, all outputs 0, a late rvalid is ignored. A following ADD passes to WB with reg_write_w=1.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the memory-stage LSU (master) and the data memory (slave).
//   dmem_req/dmem_we/dmem_be/dmem_addr/dmem_wdata : request side, driven by the LSU
//   dmem_ready : request accepted this cycle
//   dmem_rvalid/dmem_rdata : load data return
interface mem_stage_lsu_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) ();
    localparam int unsigned NB = XLEN / 8;

    logic              dmem_req;
    logic              dmem_we;
    logic [NB-1:0]     dmem_be;
    logic [ADDR_W-1:0] dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_ready;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: handshaked data-memory access with wait states,
// pipeline stall, misaligned/illegal access detection, and the MEM/WB register.
//   clk, rst (async, active-low)
//   *_m inputs : M-stage control/data, held stable by upstream while stall_m=1
//   stall_m    : hold IF..M stages
//   dmem       : data-memory master port (request, byte enables, data return)
//   *_w outputs: MEM/WB pipeline register
module mem_stage_lsu #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_m,
    input  logic              reg_write_m,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic              result_src_m,
    input  logic [2:0]        funct3_m,
    input  logic [4:0]        rd_m,
    input  logic [XLEN-1:0]   pc_plus4_m,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic [XLEN-1:0]   write_data_m,
    output logic              stall_m,
    mem_stage_lsu_if.master   dmem,
    output logic              valid_w,
    output logic              reg_write_w,
    output logic              result_src_w,
    output logic              fault_w,
    output logic [4:0]        rd_w,
    output logic [XLEN-1:0]   pc_plus4_w,
    output logic [XLEN-1:0]   alu_result_w,
    output logic [XLEN-1:0]   read_data_w
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            state_q;

    logic [ADDR_W-1:0] addr_c;
    logic [OW-1:0]     off_c;
    logic [1:0]        size_c;
    logic              legal_f3_c;
    logic              misaligned_c;
    logic              mem_op_c;
    logic              fault_c;
    logic              legal_op_c;
    logic              is_load_c;
    logic              is_store_c;
    logic              req_c;
    logic              done_c;
    logic              stall_c;
    logic [NB-1:0]     size_mask_c;
    logic [XLEN-1:0]   lane_c;
    logic [XLEN-1:0]   ld_c;

    assign addr_c     = alu_result_m[ADDR_W-1:0];
    assign off_c      = addr_c[OW-1:0];
    assign size_c     = funct3_m[1:0];
    assign is_load_c  = mem_read_m;
    assign is_store_c = mem_write_m & ~mem_read_m;

    // Access-type legality: D and WU exist only on RV64
    always_comb begin
        legal_f3_c = 1'b0;
        case (funct3_m)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3_c = 1'b1;
            3'b011, 3'b110:                         legal_f3_c = (XLEN == 64);
            default:                                legal_f3_c = 1'b0;
        endcase
    end

    // Natural alignment check against the access size
    always_comb begin
        misaligned_c = 1'b0;
        case (size_c)
            2'd1:    misaligned_c = off_c[0];
            2'd2:    misaligned_c = |off_c[1:0];
            2'd3:    misaligned_c = |off_c;
            default: misaligned_c = 1'b0;
        endcase
    end

    assign mem_op_c   = valid_m & (mem_read_m | mem_write_m);
    assign fault_c    = mem_op_c & (~legal_f3_c | misaligned_c);
    assign legal_op_c = mem_op_c & ~fault_c;

    // Request and completion per handshake state
    always_comb begin
        req_c  = 1'b0;
        done_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_c  = legal_op_c;
                done_c = legal_op_c & is_store_c & dmem.dmem_ready;
            end
            S_REQ: begin
                req_c  = 1'b1;
                done_c = is_store_c & dmem.dmem_ready;
            end
            S_WAIT: done_c = dmem.dmem_rvalid;
            default: begin
                req_c  = 1'b0;
                done_c = 1'b0;
            end
        endcase
    end

    assign stall_c = legal_op_c & ~done_c;

    // Reset forces the combinational handshake outputs low even with an op presented
    assign stall_m       = stall_c & rst;
    assign dmem.dmem_req = req_c & rst;
    assign dmem.dmem_we  = dmem.dmem_req & is_store_c;

    always_comb begin
        size_mask_c = NB'(1);
        case (size_c)
            2'd0:    size_mask_c = NB'(1);
            2'd1:    size_mask_c = NB'(3);
            2'd2:    size_mask_c = NB'(15);
            default: size_mask_c = NB'(255);
        endcase
    end

    assign dmem.dmem_be    = dmem.dmem_req ? NB'(size_mask_c << off_c) : '0;
    assign dmem.dmem_addr  = {addr_c[ADDR_W-1:OW], OW'(0)};
    assign dmem.dmem_wdata = write_data_m << {off_c, 3'b000};

    // Load formatting: move the addressed lane to bit 0, then extend
    assign lane_c = dmem.dmem_rdata >> {off_c, 3'b000};

    always_comb begin
        ld_c = lane_c;
        case (funct3_m)
            3'b000:  ld_c = XLEN'($signed(lane_c[7:0]));
            3'b001:  ld_c = XLEN'($signed(lane_c[15:0]));
            3'b010:  ld_c = XLEN'($signed(lane_c[31:0]));
            3'b100:  ld_c = XLEN'(lane_c[7:0]);
            3'b101:  ld_c = XLEN'(lane_c[15:0]);
            3'b110:  ld_c = XLEN'(lane_c[31:0]);
            default: ld_c = lane_c;
        endcase
    end

    // Handshake state and MEM/WB register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 1'b0;
            fault_w      <= 1'b0;
            rd_w         <= '0;
            pc_plus4_w   <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (legal_op_c) begin
                        if (!dmem.dmem_ready) state_q <= S_REQ;
                        else if (!is_store_c) state_q <= S_WAIT;
                    end
                end
                S_REQ: begin
                    if (dmem.dmem_ready) state_q <= is_store_c ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (dmem.dmem_rvalid) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 1'b0;
            fault_w      <= 1'b0;
            rd_w         <= '0;
            pc_plus4_w   <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
            if (fault_c) begin
                // Faulting access retires as a bubble carrying the bad address
                fault_w      <= 1'b1;
                alu_result_w <= alu_result_m;
            end else if (valid_m && !stall_c) begin
                valid_w      <= 1'b1;
                reg_write_w  <= reg_write_m;
                result_src_w <= result_src_m;
                rd_w         <= rd_m;
                pc_plus4_w   <= pc_plus4_m;
                alu_result_w <= alu_result_m;
                read_data_w  <= (legal_op_c && is_load_c) ? ld_c : '0;
            end
        end
    end
endmodule
